// File: rtl/ptos_pkg.sv
// rtl/ptos_pkg.sv - shared symbol constants and scheduler state encoding
package ptos_pkg;

  // COM symbol used as the link IDLE filler
  localparam logic [7:0] IDLE_SYM = 8'hBC;

  // Serial bit times per 8-bit symbol slot
  localparam int BITS_PER_SYM = 8;

  typedef enum logic {
    TRAIN = 1'b0,
    RUN   = 1'b1
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter_onehot.sv
// rtl/rr_arbiter_onehot.sv - combinational round-robin arbiter with one-hot grant
module rr_arbiter_onehot #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic          any
);

  // Scan offsets from farthest to nearest so the requester closest to rr_ptr wins
  always_comb begin
    grant = '0;
    for (int k = N - 1; k >= 0; k--) begin
      for (int j = 0; j < N; j++) begin
        if (req[PW'(j)] && ((int'(rr_ptr) + k) % N) == j) begin
          grant         = '0;
          grant[PW'(j)] = 1'b1;
        end
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/ptos_idle_scheduler.sv
// rtl/ptos_idle_scheduler.sv - per-slot byte/IDLE scheduler feeding the serializer
module ptos_idle_scheduler #(
  parameter int         NUM_REQ      = 4,
  parameter logic [7:0] IDLE_SYM     = ptos_pkg::IDLE_SYM,
  parameter int         MIN_IDLE     = 4,
  parameter int         BITS_PER_SYM = ptos_pkg::BITS_PER_SYM
) (
  input  logic                 clk32f,
  input  logic                 reset,
  input  logic                 link_en,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] data_in,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [7:0]           sym_out,
  output logic                 load,
  output logic                 active,
  output logic                 trained
);

  import ptos_pkg::*;

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BITS_PER_SYM);

  sched_state_t         state;
  logic [CW-1:0]        bit_cnt;
  logic [3:0]           idle_cnt;
  logic [3:0]           idle_next;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        win_idx;
  logic [PW-1:0]        ptr_next;
  logic [7:0]           win_byte;
  logic [NUM_REQ-1:0]   grant;
  logic                 any;
  logic                 slot_end;

  rr_arbiter_onehot #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .grant  (grant),
    .any    (any)
  );

  assign slot_end  = (bit_cnt == CW'(BITS_PER_SYM - 1));
  assign idle_next = (idle_cnt == 4'(MIN_IDLE)) ? idle_cnt : idle_cnt + 4'd1;
  assign ptr_next  = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  // Recover the winner index and its byte from the one-hot grant
  always_comb begin
    win_idx  = '0;
    win_byte = IDLE_SYM;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[PW'(k)]) begin
        win_idx  = PW'(k);
        win_byte = 8'(data_in >> (8 * k));
      end
    end
  end

  // Free-running symbol slot counter
  always_ff @(posedge clk32f) begin
    if (reset) begin
      bit_cnt <= '0;
    end else if (slot_end) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Training/run FSM; all slot decisions are registered on the slot_end edge
  always_ff @(posedge clk32f) begin
    if (reset) begin
      state    <= TRAIN;
      idle_cnt <= '0;
      rr_ptr   <= '0;
      sym_out  <= IDLE_SYM;
      active   <= 1'b0;
      load     <= 1'b0;
      gnt      <= '0;
      trained  <= 1'b0;
    end else begin
      load <= 1'b0;
      gnt  <= '0;
      if (slot_end) begin
        load    <= 1'b1;
        sym_out <= IDLE_SYM;
        active  <= 1'b0;
        unique case (state)
          TRAIN: begin
            idle_cnt <= idle_next;
            if (link_en && idle_next == 4'(MIN_IDLE)) begin
              state   <= RUN;
              trained <= 1'b1;
            end
          end
          RUN: begin
            if (!link_en) begin
              state    <= TRAIN;
              idle_cnt <= '0;
              trained  <= 1'b0;
            end else if (any) begin
              sym_out <= win_byte;
              active  <= 1'b1;
              gnt     <= grant;
              rr_ptr  <= ptr_next;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ptos_idle_scheduler.sv
// tb/tb_ptos_idle_scheduler.sv - self-checking bench for ptos_idle_scheduler
module tb_ptos_idle_scheduler;

  localparam int N        = 4;
  localparam int MIN_IDLE = 4;
  localparam int SLOT     = 8;

  logic          clk32f;
  logic          reset;
  logic          link_en;
  logic [N-1:0]  req;
  logic [8*N-1:0] data_in;
  logic [N-1:0]  gnt;
  logic [7:0]    sym_out;
  logic          load;
  logic          active;
  logic          trained;

  int checks = 0;
  int errors = 0;

  // reference model state, slot-level view
  int         m_pos   = 0;
  bit         m_run   = 0;
  int         m_idle  = 0;
  int         m_ptr   = 0;
  logic [7:0] m_sym   = 8'hBC;
  bit         m_act   = 0;
  bit         m_load  = 0;
  logic [N-1:0] m_gnt = '0;

  ptos_idle_scheduler dut (
    .clk32f  (clk32f),
    .reset   (reset),
    .link_en (link_en),
    .req     (req),
    .data_in (data_in),
    .gnt     (gnt),
    .sym_out (sym_out),
    .load    (load),
    .active  (active),
    .trained (trained)
  );

  initial clk32f = 1'b0;
  always #5 clk32f = ~clk32f;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic          rs;
    logic          le;
    logic [N-1:0]  rq;
    logic [8*N-1:0] d;
    rs = reset;
    le = link_en;
    rq = req;
    d  = data_in;
    @(posedge clk32f);
    #1;
    if (rs) begin
      m_pos = 0; m_run = 0; m_idle = 0; m_ptr = 0;
      m_sym = 8'hBC; m_act = 0; m_load = 0; m_gnt = '0;
    end else begin
      m_load = 0;
      m_gnt  = '0;
      if (m_pos == SLOT - 1) begin
        m_pos  = 0;
        m_load = 1;
        m_sym  = 8'hBC;
        m_act  = 0;
        if (!m_run) begin
          if (m_idle < MIN_IDLE) m_idle++;
          if (le && m_idle == MIN_IDLE) m_run = 1;
        end else if (!le) begin
          m_run  = 0;
          m_idle = 0;
        end else begin
          for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (rq[i]) begin
              m_sym = d[8*i +: 8];
              m_act = 1;
              m_gnt = N'(1 << i);
              m_ptr = (i + 1) % N;
              break;
            end
          end
        end
      end else begin
        m_pos++;
      end
    end
    chk("model_sym", 32'(sym_out), 32'(m_sym));
    chk("model_active", 32'(active), 32'(m_act));
    chk("model_load", 32'(load), 32'(m_load));
    chk("model_gnt", 32'(gnt), 32'(m_gnt));
    chk("model_trained", 32'(trained), 32'(m_run));
  endtask

  task automatic wait_load(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (load !== 1'b1 && n < 2 * SLOT);
    chk(tag, 32'(load), 32'd1);
  endtask

  task automatic train_check(input string tag);
    int loads;
    logic [N-1:0] seen;
    loads = 0;
    seen  = '0;
    for (int i = 1; i <= 5 * SLOT; i++) begin
      tick();
      if (load === 1'b1) loads++;
      seen |= gnt;
      if (i == 4 * SLOT - 1) chk({tag, "_untrained"}, 32'(trained), 32'd0);
      if (i == 4 * SLOT)     chk({tag, "_trained"}, 32'(trained), 32'd1);
      chk({tag, "_idle_sym"}, 32'(sym_out), 32'hBC);
    end
    chk({tag, "_loads"}, 32'(loads), 32'd5);
    chk({tag, "_no_gnt"}, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [7:0] exp_bytes [5];
    logic [N-1:0] exp_gnts [5];

    reset   = 1'b1;
    link_en = 1'b1;
    req     = '0;
    data_in = '0;
    repeat (3) tick();
    chk("reset_sym", 32'(sym_out), 32'hBC);
    chk("reset_load", 32'(load), 32'd0);
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_trained", 32'(trained), 32'd0);

    reset = 1'b0;
    train_check("train1");

    // single requester streams one byte per slot
    req     = 4'b0001;
    data_in = 32'h0000_005A;
    for (int s = 0; s < 2; s++) begin
      wait_load("r0_load");
      chk("r0_sym", 32'(sym_out), 32'h5A);
      chk("r0_active", 32'(active), 32'd1);
      chk("r0_gnt", 32'(gnt), 32'b0001);
    end

    // grant requester 3 once so the pointer returns to 0
    req     = 4'b1000;
    data_in = 32'h4433_2211;
    wait_load("r3_load");
    chk("r3_gnt", 32'(gnt), 32'b1000);

    // all requesting: strict rotation
    req = 4'b1111;
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    exp_gnts  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int s = 0; s < 5; s++) begin
      wait_load("all_load");
      chk("all_gnt", 32'(gnt), 32'(exp_gnts[s]));
      chk("all_sym", 32'(sym_out), 32'(exp_bytes[s]));
    end

    // move pointer to 2, then sparse requests
    req = 4'b0010;
    wait_load("r1_load");
    chk("r1_gnt", 32'(gnt), 32'b0010);
    req = 4'b1010;
    exp_gnts[0] = 4'b1000;
    exp_gnts[1] = 4'b0010;
    exp_gnts[2] = 4'b1000;
    for (int s = 0; s < 3; s++) begin
      wait_load("sparse_load");
      chk("sparse_gnt", 32'(gnt), 32'(exp_gnts[s]));
    end

    // link drop for one slot, then retrain
    link_en = 1'b0;
    wait_load("drop_load");
    chk("drop_sym", 32'(sym_out), 32'hBC);
    chk("drop_active", 32'(active), 32'd0);
    chk("drop_trained", 32'(trained), 32'd0);
    link_en = 1'b1;
    for (int s = 0; s < MIN_IDLE; s++) begin
      wait_load("retrain_load");
      chk("retrain_idle_gnt", 32'(gnt), 32'd0);
      chk("retrain_idle_active", 32'(active), 32'd0);
    end
    wait_load("retrain_first");
    chk("retrain_first_gnt", 32'(gnt), 32'b0010);

    // reset three cycles into a data slot
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("midreset_sym", 32'(sym_out), 32'hBC);
    chk("midreset_active", 32'(active), 32'd0);
    chk("midreset_load", 32'(load), 32'd0);
    chk("midreset_gnt", 32'(gnt), 32'd0);
    reset = 1'b0;
    req   = '0;
    train_check("train2");

    // randomized traffic against the model
    for (int i = 0; i < 1200; i++) begin
      req     = N'($urandom);
      data_in = $urandom;
      link_en = ($urandom_range(0, 199) != 0);
      reset   = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ptos_idle_scheduler.md
Name: ptos_idle_scheduler

Overview:
- Sequences the parallel-to-serial IDLE serializer by choosing, once per 8-bit symbol slot, which byte it loads next.
- After reset or link enable, it sends a minimum run of IDLE (COM, 0xBC) symbols.
- It then arbitrates round-robin among NUM_REQ byte sources and inserts IDLE in any slot that has no request.
- It sits between the lane byte sources and the serializer, and drives the serializer's active flag and byte-load strobe.

Parameters:
- NUM_REQ, 4, number of byte requesters (2..8).
- IDLE_SYM, 8'hBC, symbol sent when no data is scheduled.
- MIN_IDLE, 4, IDLE slots required after reset or link enable before any grant (1..15).
- BITS_PER_SYM, 8, clk32f cycles per symbol slot.

Ports:
- clk32f  in  1  bit-rate clock; the only clock.
- reset  in  1  synchronous, active-high.
- link_en  in  1  high permits data scheduling; low forces retraining.
- req  in  NUM_REQ  per-requester request level.
- data_in  in  8*NUM_REQ  requester k's byte is on bits [8k+7:8k].
- gnt  out  NUM_REQ  one-hot, one-cycle pulse: the byte of that requester was captured.
- sym_out  out  8  symbol presented to the serializer.
- load  out  1  one-cycle pulse: sym_out is a new symbol; the serializer starts shifting it.
- active  out  1  high when sym_out is requester data; low when it is IDLE_SYM.
- trained  out  1  high in RUN state.

Behaviour:
- Reset (sampled on a clk32f edge) sets: bit_cnt=0, state=TRAIN, idle_cnt=0, rr_ptr=0, sym_out=IDLE_SYM, active=0, load=0, gnt=0, trained=0.
- bit_cnt counts 0..BITS_PER_SYM-1 and wraps.
- slot_end = (bit_cnt==BITS_PER_SYM-1). All decisions are taken only on slot_end edges.
- On a slot_end edge the block registers sym_out, active and gnt. load=1 for exactly the following cycle (bit_cnt==0). gnt pulses in that same cycle.
- The first load after reset release occurs in the cycle where bit_cnt returns to 0, i.e. 8 cycles after release.
- TRAIN state:
  - Every slot sends IDLE_SYM with active=0 and no gnt.
  - idle_cnt increments per slot.
  - When idle_cnt reaches MIN_IDLE with link_en=1, go to RUN at that slot_end. That slot is still IDLE; data can first be scheduled in the next slot.
  - If link_en=0, idle_cnt holds at saturation (MIN_IDLE) and the state stays TRAIN.
- RUN state:
  - If link_en=0 at slot_end: send IDLE, go to TRAIN, clear idle_cnt and trained.
  - Else if any req: choose the first asserted requester searching from rr_ptr upward with wrap. Register its data_in byte into sym_out, set active=1, pulse its gnt, and set rr_ptr = winner+1 (mod NUM_REQ).
  - Else: send IDLE_SYM with active=0; rr_ptr is unchanged.
- Requesters hold req and data stable until their gnt pulse. After gnt they may deassert, or keep req high for another byte.
- req changes between slot_end edges are ignored.
- At most one gnt per slot, so the maximum per-requester rate is one byte per 8 cycles.
- trained = (state==RUN), registered.
- A reset mid-slot aborts the slot. sym_out returns to IDLE_SYM immediately; no gnt is issued for the aborted slot.
- rr_ptr width is clog2(NUM_REQ); the increment wraps at NUM_REQ, not at a power of two.

Decomposition:
- Shared package (ptos_pkg) holds:
  - IDLE_SYM (COM 0xBC), as the common PCIe symbol constant.
  - The state encoding TRAIN=0, RUN=1.
  - BITS_PER_SYM.
- One natural sub-module: rr_arbiter_onehot (inputs req, rr_ptr; outputs one-hot grant, any).
  - It is purely combinational.
  - It is reusable by later multi-lane blocks.

Test Plan:
- Reset held 3 cycles, then released with link_en=1 and no req:
  - load pulses every 8 cycles.
  - sym_out=0xBC and active=0 throughout.
  - trained rises at the 4th slot_end; no gnt is issued.
- After training, req=4'b0001 with data_in[7:0]=0x5A held:
  - next load shows sym_out=0x5A, active=1, gnt=4'b0001.
  - the byte repeats every slot while req is held.
- req=4'b1111 held with distinct bytes 0x11/0x22/0x33/0x44:
  - grants cycle 0001, 0010, 0100, 1000, 0001.
  - sym_out follows 0x11, 0x22, 0x33, 0x44.
- req=4'b1010 with rr_ptr=2:
  - grant order is 1000, then 0010, then 1000.
  - no grant goes to an unrequested index.
- link_en dropped mid-run:
  - the next slot is IDLE with active=0 and trained=0.
  - on link_en return, exactly 4 IDLE slots precede the first gnt.
- Reset asserted at bit_cnt=3 of a data slot:
  - the next cycle has sym_out=0xBC, active=0, load=0, gnt=0.
  - retraining repeats as in the first scenario.
